// File: rtl/debug_hex_overlay.sv
// debug_hex_overlay: draws an up-to-8-digit hex value into a pixel stream.
// Two-stage pipeline: stage 1 computes the glyph lookup and drives the ROM,
// stage 2 composites the returned glyph bit over the delayed input colour.
// The shown value is copied from a pending register only on frame_start,
// so the digits never change partway through a frame.
module debug_hex_overlay #(
  parameter int unsigned ORIGIN_X   = 8,
  parameter int unsigned ORIGIN_Y   = 8,
  parameter int unsigned NUM_DIGITS = 8,
  parameter logic [14:0] FG_COLOUR  = 15'h7FFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] value_in,
  input  logic        value_load,
  input  logic        frame_start,
  input  logic        overlay_enable,
  input  logic        pix_valid_in,
  input  logic [8:0]  pix_x_in,
  input  logic [7:0]  pix_y_in,
  input  logic [14:0] pix_colour_in,
  output logic [3:0]  rom_char,
  output logic [2:0]  rom_x,
  output logic [2:0]  rom_y,
  input  logic        rom_pixel,
  output logic        pix_valid_out,
  output logic [8:0]  pix_x_out,
  output logic [7:0]  pix_y_out,
  output logic [14:0] pix_colour_out
);

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + 8 * NUM_DIGITS);
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + 8);

  logic [31:0] pending;
  logic [31:0] displayed;

  logic [9:0]  x_wide;
  logic [9:0]  y_wide;
  logic [5:0]  dx;
  logic [2:0]  dy;
  logic [2:0]  digit;
  logic [3:0]  nibble;
  logic        in_box;

  logic        s1_valid;
  logic [8:0]  s1_x_pos;
  logic [7:0]  s1_y_pos;
  logic [14:0] s1_colour;
  logic        s1_in_box;
  logic [3:0]  s1_char;
  logic [2:0]  s1_col;
  logic [2:0]  s1_row;

  // Pending/displayed value registers; load+frame_start together bypasses pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      displayed <= '0;
    end else begin
      if (value_load)
        pending <= value_in;
      if (frame_start)
        displayed <= value_load ? value_in : pending;
    end
  end

  // Box test and glyph coordinates for the pixel presented this cycle.
  // Only the low bits of the offsets are needed; truncated subtraction gives
  // the same bits as the full 10-bit difference.
  always_comb begin
    x_wide = {1'b0, pix_x_in};
    y_wide = {2'b00, pix_y_in};
    in_box = pix_valid_in & overlay_enable &
             (x_wide >= X_LO) & (x_wide < X_HI) &
             (y_wide >= Y_LO) & (y_wide < Y_HI);
    dx     = pix_x_in[5:0] - X_LO[5:0];
    dy     = pix_y_in[2:0] - Y_LO[2:0];
    digit  = dx[5:3];
  end

  // Nibble for the selected digit, leftmost digit = most significant shown nibble.
  always_comb begin
    nibble = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (digit == 3'(d))
        nibble = displayed[4*(NUM_DIGITS-1-d) +: 4];
    end
  end

  // Stage 1: capture the pixel and the glyph lookup; out-of-box lookups read as 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_x_pos  <= '0;
      s1_y_pos  <= '0;
      s1_colour <= '0;
      s1_in_box <= 1'b0;
      s1_char   <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
    end else begin
      s1_valid  <= pix_valid_in;
      s1_x_pos  <= pix_x_in;
      s1_y_pos  <= pix_y_in;
      s1_colour <= pix_colour_in;
      s1_in_box <= in_box;
      s1_char   <= in_box ? nibble : '0;
      s1_col    <= in_box ? dx[2:0] : '0;
      s1_row    <= in_box ? dy : '0;
    end
  end

  // The glyph ROM is addressed straight from the stage-1 registers.
  always_comb begin
    rom_char = s1_char;
    rom_x    = s1_col;
    rom_y    = s1_row;
  end

  // Stage 2: composite the foreground colour where the glyph bit is set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_out  <= 1'b0;
      pix_x_out      <= '0;
      pix_y_out      <= '0;
      pix_colour_out <= '0;
    end else begin
      pix_valid_out  <= s1_valid;
      pix_x_out      <= s1_x_pos;
      pix_y_out      <= s1_y_pos;
      pix_colour_out <= (s1_in_box & rom_pixel) ? FG_COLOUR : s1_colour;
    end
  end

endmodule

// File: tb/tb_debug_hex_overlay.sv
// Directed testbench for debug_hex_overlay with a behavioural glyph ROM.
module tb_debug_hex_overlay;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] value_in;
  logic        value_load;
  logic        frame_start;
  logic        overlay_enable;
  logic        pix_valid_in;
  logic [8:0]  pix_x_in;
  logic [7:0]  pix_y_in;
  logic [14:0] pix_colour_in;
  logic [3:0]  rom_char;
  logic [2:0]  rom_x;
  logic [2:0]  rom_y;
  logic        rom_pixel;
  logic        pix_valid_out;
  logic [8:0]  pix_x_out;
  logic [7:0]  pix_y_out;
  logic [14:0] pix_colour_out;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [14:0] FG = 15'h7FFF;

  debug_hex_overlay #(
    .ORIGIN_X(8),
    .ORIGIN_Y(8),
    .NUM_DIGITS(8),
    .FG_COLOUR(15'h7FFF)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .value_in(value_in),
    .value_load(value_load),
    .frame_start(frame_start),
    .overlay_enable(overlay_enable),
    .pix_valid_in(pix_valid_in),
    .pix_x_in(pix_x_in),
    .pix_y_in(pix_y_in),
    .pix_colour_in(pix_colour_in),
    .rom_char(rom_char),
    .rom_x(rom_x),
    .rom_y(rom_y),
    .rom_pixel(rom_pixel),
    .pix_valid_out(pix_valid_out),
    .pix_x_out(pix_x_out),
    .pix_y_out(pix_y_out),
    .pix_colour_out(pix_colour_out)
  );

  always #5 clock = ~clock;

  // 8x8 font: row 0 in the top byte, column 0 is the MSB of each row.
  function automatic logic [63:0] font(input logic [3:0] c);
    case (c)
      4'h0: font = 64'h003C_7E66_667E_3C00;
      4'h1: font = 64'h0018_3818_1818_7E00;
      4'h2: font = 64'h003C_660C_1830_7E00;
      4'h3: font = 64'h003C_661C_0666_3C00;
      4'h4: font = 64'h000C_1C2C_4C7E_0C00;
      4'h5: font = 64'h007E_607C_0666_3C00;
      4'h6: font = 64'h003C_607C_6666_3C00;
      4'h7: font = 64'h007E_060C_1818_1800;
      4'h8: font = 64'h003C_663C_6666_3C00;
      4'h9: font = 64'h003C_6666_3E06_3C00;
      4'hA: font = 64'h0018_3C66_7E66_6600;
      4'hB: font = 64'h007C_667C_6666_7C00;
      4'hC: font = 64'h003C_6660_6066_3C00;
      4'hD: font = 64'h0078_6C66_666C_7800;
      4'hE: font = 64'h007E_607C_6060_7E00;
      default: font = 64'h007E_607C_6060_6000;
    endcase
  endfunction

  function automatic logic glyph_bit(input logic [3:0] c, input logic [2:0] gx, input logic [2:0] gy);
    logic [63:0] g;
    int unsigned idx;
    g   = font(c);
    idx = 63 - (int'(gy) * 8 + int'(gx));
    return g[idx];
  endfunction

  assign rom_pixel = glyph_bit(rom_char, rom_x, rom_y);

  // Reference output word {valid, x, y, colour} for one input beat.
  function automatic logic [32:0] model(input logic v, input logic en, input logic [8:0] x,
                                        input logic [7:0] y, input logic [14:0] c,
                                        input logic [31:0] disp);
    int unsigned dxi, dyi, dig;
    logic [3:0] nib;
    logic [14:0] oc;
    oc = c;
    if (v && en && x >= 8 && x < 72 && y >= 8 && y < 16) begin
      dxi = int'(x) - 8;
      dyi = int'(y) - 8;
      dig = dxi / 8;
      nib = 4'((disp >> (4 * (7 - dig))) & 32'hF);
      if (glyph_bit(nib, 3'(dxi % 8), 3'(dyi))) oc = FG;
    end
    return {v, x, y, oc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one valid pixel for one cycle; afterwards stage 1 holds it.
  task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [14:0] c);
    pix_valid_in  = 1'b1;
    pix_x_in      = x;
    pix_y_in      = y;
    pix_colour_in = c;
    tick();
    pix_valid_in  = 1'b0;
    pix_x_in      = '0;
    pix_y_in      = '0;
    pix_colour_in = '0;
  endtask

  task automatic rom_chk(input string tag, input logic [3:0] c, input logic [2:0] x, input logic [2:0] y);
    check(tag, {52'd0, rom_char, rom_x, rom_y}, {52'd0, c, x, y});
  endtask

  task automatic out_chk(input string tag, input logic [8:0] x, input logic [7:0] y, input logic [14:0] c);
    check(tag, {31'd0, pix_valid_out, pix_x_out, pix_y_out, pix_colour_out},
               {31'd0, 1'b1, x, y, c});
  endtask

  task automatic load_and_show(input logic [31:0] v);
    value_in    = v;
    value_load  = 1'b1;
    tick();
    value_load  = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [32:0] cur_exp, prev_exp;
  logic        rv;
  logic [8:0]  rx;
  logic [7:0]  ry;
  logic [14:0] rc;

  initial begin
    reset_n = 1'b0; value_in = '0; value_load = 1'b0; frame_start = 1'b0;
    overlay_enable = 1'b0; pix_valid_in = 1'b0; pix_x_in = '0; pix_y_in = '0;
    pix_colour_in = '0;
    tick();
    tick();
    check("reset_outputs", {12'd0, rom_char, rom_x, rom_y, pix_valid_out, pix_x_out,
                            pix_y_out, pix_colour_out}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Passthrough with overlay disabled, including a glyph-set position.
    load_and_show(32'h0123ABCD);
    send(9'd20, 8'd10, 15'h1234);
    rom_chk("pass_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("pass_out", 9'd20, 8'd10, 15'h1234);
    send(9'd9, 8'd10, 15'h0555);
    rom_chk("pass_glyph_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("pass_glyph_out", 9'd9, 8'd10, 15'h0555);

    // Digit rendering of 0123ABCD.
    overlay_enable = 1'b1;
    send(9'd8, 8'd10, 15'h0AAA);
    rom_chk("d0_col0_rom", 4'h0, 3'd0, 3'd2);
    tick();
    out_chk("d0_col0_out", 9'd8, 8'd10, 15'h0AAA);
    send(9'd9, 8'd10, 15'h0AAA);
    rom_chk("d0_col1_rom", 4'h0, 3'd1, 3'd2);
    tick();
    out_chk("d0_col1_out", 9'd9, 8'd10, FG);
    send(9'd19, 8'd10, 15'h0123);
    rom_chk("d1_rom", 4'h1, 3'd3, 3'd2);
    tick();
    out_chk("d1_out", 9'd19, 8'd10, FG);
    send(9'd66, 8'd10, 15'h0123);
    rom_chk("d7_rom", 4'hD, 3'd2, 3'd2);
    tick();
    out_chk("d7_out", 9'd66, 8'd10, FG);

    // Pending value must not appear before frame_start.
    value_in = 32'hFFFFFFFF; value_load = 1'b1;
    tick();
    value_load = 1'b0;
    send(9'd8, 8'd10, 15'h0001);
    rom_chk("held_old", 4'h0, 3'd0, 3'd2);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send(9'd8, 8'd10, 15'h0001);
    rom_chk("shown_new", 4'hF, 3'd0, 3'd2);
    tick();

    // Box edges with every digit F so an aliased lookup would be visible.
    send(9'd7, 8'd8, 15'h0111);
    rom_chk("edge_x_lo_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("edge_x_lo_out", 9'd7, 8'd8, 15'h0111);
    send(9'd72, 8'd8, 15'h0222);
    rom_chk("edge_x_hi_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("edge_x_hi_out", 9'd72, 8'd8, 15'h0222);
    send(9'd8, 8'd16, 15'h0333);
    rom_chk("edge_y_hi_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("edge_y_hi_out", 9'd8, 8'd16, 15'h0333);
    send(9'd8, 8'd7, 15'h0444);
    rom_chk("edge_y_lo_rom", 4'h0, 3'd0, 3'd0);
    tick();
    out_chk("edge_y_lo_out", 9'd8, 8'd7, 15'h0444);
    send(9'd71, 8'd15, 15'h0555);
    rom_chk("edge_in_br_rom", 4'hF, 3'd7, 3'd7);
    tick();
    out_chk("edge_in_br_out", 9'd71, 8'd15, 15'h0555);
    send(9'd8, 8'd8, 15'h0666);
    rom_chk("edge_in_tl_rom", 4'hF, 3'd0, 3'd0);
    tick();

    // Simultaneous load and frame_start bypasses into the displayed value.
    value_in = 32'h00000005; value_load = 1'b1; frame_start = 1'b1;
    tick();
    value_load = 1'b0; frame_start = 1'b0;
    send(9'd71, 8'd10, 15'h0000);
    rom_chk("bypass_d7", 4'h5, 3'd7, 3'd2);
    send(9'd8, 8'd10, 15'h0000);
    rom_chk("bypass_d0", 4'h0, 3'd0, 3'd2);
    tick();

    // Streaming with random gaps against the reference model.
    load_and_show(32'h1A2B3C4D);
    prev_exp = '0;
    for (int i = 0; i < 100; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rx = 9'($urandom_range(0, 80));
      ry = 8'($urandom_range(4, 18));
      rc = 15'($urandom);
      pix_valid_in = rv; pix_x_in = rx; pix_y_in = ry; pix_colour_in = rc;
      cur_exp = model(rv, 1'b1, rx, ry, rc, 32'h1A2B3C4D);
      tick();
      if (i > 0)
        check("stream", {31'd0, pix_valid_out, pix_x_out, pix_y_out, pix_colour_out},
                        {31'd0, prev_exp});
      prev_exp = cur_exp;
    end
    pix_valid_in = 1'b0;
    tick();
    check("stream_last", {31'd0, pix_valid_out, pix_x_out, pix_y_out, pix_colour_out},
                         {31'd0, prev_exp});

    // Reset asserted mid-stream clears everything immediately.
    pix_valid_in = 1'b1; pix_x_in = 9'd9; pix_y_in = 8'd10; pix_colour_in = 15'h0123;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("reset_mid", {12'd0, rom_char, rom_x, rom_y, pix_valid_out, pix_x_out,
                        pix_y_out, pix_colour_out}, 64'd0);
    tick();
    reset_n = 1'b1;
    pix_x_in = 9'd100; pix_y_in = 8'd50; pix_colour_in = 15'h2468;
    tick();
    check("post_reset_valid", {63'd0, pix_valid_out}, 64'd0);
    tick();
    out_chk("post_reset_pass", 9'd100, 8'd50, 15'h2468);
    pix_valid_in = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
